// File: rtl/pwls_multi_osc.sv
// Time-multiplexed oscillator bank: NUM_CHANNELS phase accumulators share one adder and wave generator.
// Optional hard sync between neighbouring channels is enabled by defining PWLS_OSC_HARD_SYNC_EN.
module pwls_multi_osc #(
  parameter int NUM_CHANNELS = 4,
  parameter int BITS         = 12,
  parameter int OCT_BITS     = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cfg_we,
  input  logic [$clog2(NUM_CHANNELS)-1:0] cfg_channel,
  input  logic [1:0]                      cfg_addr,
  input  logic [BITS-1:0]                 cfg_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [BITS-1:0]                 out_sample,
  output logic [$clog2(NUM_CHANNELS)-1:0] out_channel,
  output logic                            out_wrap
);

  localparam int CW      = $clog2(NUM_CHANNELS);
  localparam int MAX_OCT = 2**OCT_BITS - 1;
  localparam int EN_BIT  = OCT_BITS;
  localparam int MODE_LO = OCT_BITS + 1;
`ifdef PWLS_OSC_HARD_SYNC_EN
  localparam int SYNC_BIT = OCT_BITS + 3;
  localparam int CTRL_W   = OCT_BITS + 4;
`else
  localparam int CTRL_W   = OCT_BITS + 3;
`endif

  localparam logic [1:0] ADDR_CTRL  = 2'd0;
  localparam logic [1:0] ADDR_MANT  = 2'd1;
  localparam logic [1:0] ADDR_PHASE = 2'd2;

  typedef enum logic [1:0] {
    MODE_SAW    = 2'd0,
    MODE_TRI    = 2'd1,
    MODE_SQUARE = 2'd2,
    MODE_NOISE  = 2'd3
  } mode_e;

  logic [BITS-1:0]   phase [NUM_CHANNELS];
  logic [CTRL_W-1:0] ctrl  [NUM_CHANNELS];
  logic [BITS-2:0]   mant  [NUM_CHANNELS];
  logic [14:0]       lfsr  [NUM_CHANNELS];
  logic [CW-1:0]     cur;

  logic              fire;
  logic [CTRL_W-1:0] cur_ctrl;
  logic [OCT_BITS-1:0] octave;
  logic [OCT_BITS-1:0] shamt;
  logic              enable;
  mode_e             mode;
  logic [BITS-1:0]   inc;
  logic [BITS-1:0]   base;
  logic [BITS:0]     sum;
  logic [BITS-1:0]   new_phase;
  logic              upd_wrap;
  logic [14:0]       lfsr_next;
  logic [BITS-1:0]   tri_wave;
  logic [BITS-1:0]   sample;

`ifdef PWLS_OSC_HARD_SYNC_EN
  logic [NUM_CHANNELS-1:0] sync_flag;
  logic [CW-1:0]           next_ch;
  assign next_ch = cur + 1'b1;
`endif

  assign fire = !out_valid || out_ready;

  // Shared datapath for the channel currently being serviced
  always_comb begin
    cur_ctrl  = ctrl[cur];
    octave    = cur_ctrl[OCT_BITS-1:0];
    enable    = cur_ctrl[EN_BIT];
    mode      = mode_e'(cur_ctrl[MODE_LO +: 2]);
    shamt     = OCT_BITS'(MAX_OCT) - octave;
    inc       = {1'b1, mant[cur]} >> shamt;
    base      = phase[cur];
`ifdef PWLS_OSC_HARD_SYNC_EN
    if (sync_flag[cur])
      base = '0;
`endif
    sum       = {1'b0, base} + {1'b0, inc};
    new_phase = sum[BITS-1:0];
    upd_wrap  = enable & sum[BITS];
    // x^15 + x^14 + 1, shifting toward bit 0 so lfsr[0] is the noise output
    lfsr_next = upd_wrap ? {lfsr[cur][0] ^ lfsr[cur][1], lfsr[cur][14:1]} : lfsr[cur];
    tri_wave  = {new_phase[BITS-2:0], 1'b0};
    if (new_phase[BITS-1])
      tri_wave = ~tri_wave;
    sample = '0;
    if (enable) begin
      case (mode)
        MODE_SAW:    sample = new_phase;
        MODE_TRI:    sample = tri_wave;
        MODE_SQUARE: sample = {BITS{new_phase[BITS-1]}};
        MODE_NOISE:  sample = {BITS{lfsr_next[0]}};
        default:     sample = '0;
      endcase
    end
  end

  // Channel state, sequencer and output register; a same-cycle PHASE write overrides the update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        phase[i] <= '0;
        ctrl[i]  <= '0;
        mant[i]  <= '0;
        lfsr[i]  <= 15'h7FFF;
      end
      cur         <= '0;
      out_valid   <= 1'b0;
      out_sample  <= '0;
      out_channel <= '0;
      out_wrap    <= 1'b0;
    end else begin
      if (fire) begin
        if (enable)
          phase[cur] <= new_phase;
        lfsr[cur]   <= lfsr_next;
        cur         <= cur + 1'b1;
        out_valid   <= 1'b1;
        out_sample  <= sample;
        out_channel <= cur;
        out_wrap    <= upd_wrap;
      end
      if (cfg_we) begin
        case (cfg_addr)
          ADDR_CTRL:  ctrl[cfg_channel]  <= cfg_data[CTRL_W-1:0];
          ADDR_MANT:  mant[cfg_channel]  <= cfg_data[BITS-2:0];
          ADDR_PHASE: phase[cfg_channel] <= cfg_data;
          default:    ;
        endcase
      end
    end
  end

`ifdef PWLS_OSC_HARD_SYNC_EN
  // A wrap on channel k arms a phase reset for channel k+1 on its next visit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_flag <= '0;
    end else if (fire) begin
      sync_flag[cur] <= 1'b0;
      if (upd_wrap && ctrl[next_ch][SYNC_BIT])
        sync_flag[next_ch] <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pwls_multi_osc.sv
// Directed self-checking bench for pwls_multi_osc (default build, hard sync disabled).
module tb_pwls_multi_osc;

  localparam int NUM_CHANNELS = 4;
  localparam int BITS         = 12;
  localparam int OCT_BITS     = 3;
  localparam int CW           = $clog2(NUM_CHANNELS);

  localparam logic [1:0] A_CTRL  = 2'd0;
  localparam logic [1:0] A_MANT  = 2'd1;
  localparam logic [1:0] A_PHASE = 2'd2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cfg_we = 1'b0;
  logic [CW-1:0]   cfg_channel = '0;
  logic [1:0]      cfg_addr = '0;
  logic [BITS-1:0] cfg_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [BITS-1:0] out_sample;
  logic [CW-1:0]   out_channel;
  logic            out_wrap;

  int check_count = 0;
  int fail_count  = 0;

  pwls_multi_osc #(
    .NUM_CHANNELS(NUM_CHANNELS),
    .BITS(BITS),
    .OCT_BITS(OCT_BITS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_we(cfg_we),
    .cfg_channel(cfg_channel),
    .cfg_addr(cfg_addr),
    .cfg_data(cfg_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sample(out_sample),
    .out_channel(out_channel),
    .out_wrap(out_wrap)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle register write
  task automatic applyStimulus(input int ch, input logic [1:0] addr, input logic [BITS-1:0] data);
    cfg_we      = 1'b1;
    cfg_channel = CW'(ch);
    cfg_addr    = addr;
    cfg_data    = data;
    step();
    cfg_we      = 1'b0;
  endtask

  // Advance until the output carries a sample for channel ch (bounded)
  task automatic grabSample(input int ch, output logic [BITS-1:0] s, output logic w);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      step();
      if (out_valid && out_channel == CW'(ch))
        found = 1'b1;
    end
    checkOutput($sformatf("visit_ch%0d", ch), 32'(found), 32'd1);
    s = out_sample;
    w = out_wrap;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [BITS-1:0] s;
    logic            w;
    logic [14:0]     ref_lfsr;
    logic [BITS-1:0] ref_phase;
    logic [BITS:0]   ref_sum;

    // Reset state
    #12;
    checkOutput("rst_valid",   32'(out_valid),   32'd0);
    checkOutput("rst_sample",  32'(out_sample),  32'd0);
    checkOutput("rst_channel", 32'(out_channel), 32'd0);
    checkOutput("rst_wrap",    32'(out_wrap),    32'd0);
    step();
    rst_n = 1'b1;
    step();
    checkOutput("first_valid",   32'(out_valid),   32'd1);
    checkOutput("first_channel", 32'(out_channel), 32'd0);
    checkOutput("first_sample",  32'(out_sample),  32'd0);
    for (int i = 1; i < 8; i++) begin
      step();
      checkOutput($sformatf("idle_ch_%0d", i),     32'(out_channel), 32'(i % NUM_CHANNELS));
      checkOutput($sformatf("idle_sample_%0d", i), 32'(out_sample),  32'd0);
    end

    // Saw on ch0, octave 7, mantissa 0: increment 0x800
    applyStimulus(0, A_MANT, 12'h000);
    applyStimulus(0, A_CTRL, 12'h00F);
    grabSample(0, s, w);
    checkOutput("saw_1", 32'(s), 32'h800);
    checkOutput("saw_1_wrap", 32'(w), 32'd0);
    step();
    checkOutput("saw_ch1_chan", 32'(out_channel), 32'd1);
    checkOutput("saw_ch1_zero", 32'(out_sample), 32'd0);
    grabSample(0, s, w);
    checkOutput("saw_2", 32'(s), 32'h000);
    checkOutput("saw_2_wrap", 32'(w), 32'd1);
    grabSample(0, s, w);
    checkOutput("saw_3", 32'(s), 32'h800);
    checkOutput("saw_3_wrap", 32'(w), 32'd0);
    applyStimulus(0, A_CTRL, 12'h000);

    // Triangle on ch1, octave 0: increment 0x010
    applyStimulus(1, A_MANT, 12'h000);
    applyStimulus(1, A_CTRL, 12'h018);
    grabSample(1, s, w);
    checkOutput("tri_1", 32'(s), 32'h020);
    grabSample(1, s, w);
    checkOutput("tri_2", 32'(s), 32'h040);
    grabSample(1, s, w);
    checkOutput("tri_3", 32'(s), 32'h060);
    applyStimulus(1, A_PHASE, 12'h800);
    grabSample(1, s, w);
    checkOutput("tri_810", 32'(s), 32'hFDF);

    // Backpressure: output must hold and no phase may advance
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput($sformatf("bp_valid_%0d", i),  32'(out_valid),   32'd1);
      checkOutput($sformatf("bp_chan_%0d", i),   32'(out_channel), 32'd1);
      checkOutput($sformatf("bp_sample_%0d", i), 32'(out_sample),  32'hFDF);
    end
    out_ready = 1'b1;
    step();
    checkOutput("bp_next_chan", 32'(out_channel), 32'd2);
    checkOutput("bp_next_sample", 32'(out_sample), 32'd0);
    grabSample(1, s, w);
    checkOutput("bp_tri_820", 32'(s), 32'hFBF);
    applyStimulus(1, A_CTRL, 12'h000);

    // Noise on ch2, octave 7: LFSR shifts on every other visit
    applyStimulus(2, A_MANT, 12'h000);
    applyStimulus(2, A_CTRL, 12'h03F);
    ref_lfsr  = 15'h7FFF;
    ref_phase = '0;
    for (int v = 0; v < 40; v++) begin
      grabSample(2, s, w);
      ref_sum   = {1'b0, ref_phase} + 13'h0800;
      ref_phase = ref_sum[BITS-1:0];
      if (ref_sum[BITS])
        ref_lfsr = {ref_lfsr[0] ^ ref_lfsr[1], ref_lfsr[14:1]};
      checkOutput($sformatf("noise_%0d", v), 32'(s), ref_lfsr[0] ? 32'hFFF : 32'h000);
      checkOutput($sformatf("noise_wrap_%0d", v), 32'(w), 32'(ref_sum[BITS]));
    end
    applyStimulus(2, A_CTRL, 12'h000);

    // Collisions on ch0: PHASE write wins storage, CTRL write applies next visit
    applyStimulus(0, A_PHASE, 12'h000);
    applyStimulus(0, A_CTRL, 12'h00F);
    grabSample(0, s, w);
    checkOutput("col_pre", 32'(s), 32'h800);
    for (int i = 0; i < NUM_CHANNELS - 1; i++) step();
    applyStimulus(0, A_PHASE, 12'h123);
    checkOutput("col_phase_chan",   32'(out_channel), 32'd0);
    checkOutput("col_phase_sample", 32'(out_sample),  32'h000);
    checkOutput("col_phase_wrap",   32'(out_wrap),    32'd1);
    grabSample(0, s, w);
    checkOutput("col_phase_next", 32'(s), 32'h923);
    checkOutput("col_phase_next_wrap", 32'(w), 32'd0);
    for (int i = 0; i < NUM_CHANNELS - 1; i++) step();
    applyStimulus(0, A_CTRL, 12'h000);
    checkOutput("col_ctrl_chan",   32'(out_channel), 32'd0);
    checkOutput("col_ctrl_sample", 32'(out_sample),  32'h123);
    checkOutput("col_ctrl_wrap",   32'(out_wrap),    32'd1);
    grabSample(0, s, w);
    checkOutput("col_ctrl_next", 32'(s), 32'h000);

    // Asynchronous reset mid-stream
    applyStimulus(3, A_CTRL, 12'h00F);
    step();
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid",  32'(out_valid),  32'd0);
    checkOutput("async_rst_sample", 32'(out_sample), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    checkOutput("restart_chan",   32'(out_channel), 32'd0);
    checkOutput("restart_valid",  32'(out_valid),   32'd1);
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (i > 0) step();
      checkOutput($sformatf("restart_sample_%0d", i), 32'(out_sample), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule

// File: doc/pwls_multi_osc.md
Name: pwls_multi_osc

Overview:
- Time-multiplexed, parametrised oscillator bank: NUM_CHANNELS phase accumulators share one adder and one waveform generator, serviced round-robin.
- Each channel has octave/mantissa pitch, enable and mode (saw, triangle, square, LFSR noise), all written through a register port.
- Emits one sample per serviced channel on a valid/ready stream to the downstream mixer; backpressure stalls the sequencer.

Parameters:
NUM_CHANNELS, 4, channels serviced; power of two, >=2
BITS, 12, phase and sample width
OCT_BITS, 3, octave field width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  register write strobe; always accepted
cfg_channel  in  $clog2(NUM_CHANNELS)  target channel
cfg_addr  in  2  0=CTRL, 1=MANT, 2=PHASE, 3=reserved (ignored)
cfg_data  in  BITS  write data
out_valid  out  1  sample available
out_ready  in  1  downstream accepts sample
out_sample  out  BITS  waveform sample
out_channel  out  $clog2(NUM_CHANNELS)  channel of out_sample
out_wrap  out  1  phase wrapped on this update

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: out_valid=0, out_sample=0, out_channel=0, out_wrap=0, sequencer index cur=0. Per channel: phase=0, CTRL=0 (disabled, saw, octave 0), MANT=0, LFSR=15'h7FFF.
- CTRL fields: [OCT_BITS-1:0]=octave, [OCT_BITS]=enable, [OCT_BITS+2:OCT_BITS+1]=mode (0 saw, 1 tri, 2 square, 3 noise). MANT uses cfg_data[BITS-2:0].
- fire = !out_valid || out_ready. On a fire cycle, channel cur is updated and cur advances mod NUM_CHANNELS. With no fire, all state holds and the outputs stay stable.
- Increment: inc = {1'b1, mant} >> ((2**OCT_BITS-1) - octave), BITS wide. Sum = phase + inc, BITS+1 bits; the carry is wrap. Disabled channel: phase holds, wrap=0, sample=0.
- Sample from the new phase p:
  - saw = p
  - tri = p[BITS-1] ? ~{p[BITS-2:0],0} : {p[BITS-2:0],0}
  - square = {BITS{p[BITS-1]}}
  - noise = {BITS{lfsr[0]}}, evaluated after any shift
- LFSR: 15-bit Fibonacci, x^15+x^14+1. Shifts once per wrap in any mode.
- Registered outputs: sample, channel and wrap appear the cycle after fire, with out_valid=1. Latency is one cycle. Throughput is one sample/cycle when out_ready=1.
- Write/update collision on the same channel in the same cycle:
  - PHASE write wins the stored phase. The emitted sample still reflects the computed update.
  - CTRL/MANT writes: the update uses the old values; the new values apply from the next visit.
- Writes to other channels are independent.
- Reset mid-stream: out_valid drops immediately (asynchronous). The bank restarts at channel 0.

Optional Feature:
PWLS_OSC_HARD_SYNC_EN:
- Defined: CTRL bit [OCT_BITS+3] = sync. When channel k wraps on its update, channel (k+1) mod NUM_CHANNELS is flagged if its sync bit is set.
- On the flagged channel's next visit, its phase is taken as 0 before adding inc, then the flag clears. The flag resets to 0.
- Not defined: bit [OCT_BITS+3] is ignored, and no flags or flag logic exist.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> out_valid=0 in the same cycle. After release, the first out_channel is 0 and every sample is 0 (all channels disabled).
- Saw, BITS=12: ch0 CTRL=enable, octave 7, MANT=0, out_ready=1 -> ch0 samples every 4th output: 0x800 (wrap 0), 0x000 (wrap 1), 0x800. Ch1-3 output 0.
- Triangle: ch1 tri, octave 0, MANT=0 -> inc=0x010. Ch1 samples 0x020, 0x040, 0x060. Phase 0x810 gives 0xFDF.
- Backpressure: out_ready=0 for 10 cycles -> out_valid=1 and sample/channel held constant, with no phase advance. After release, the next out_channel is the successor.
- Noise: ch2 noise, octave 7, MANT=0 -> LFSR shifts on alternate visits. Samples follow the reference LFSR sequence from 0x7FFF (first shift gives lfsr[0]=1, so sample 0xFFF).
- Collision: write PHASE=0x123 to ch0 in ch0's fire cycle -> the emitted sample is old phase+inc, and the next ch0 visit yields 0x123+inc. With PWLS_OSC_HARD_SYNC_EN, a ch0 wrap resets synced ch1 to phase inc.
